// File: rtl/btb_next_pc_if.sv
// Fetch/Execute signal bundle for the next-PC generator and branch target buffer.
// The master drives hazard/PHT/Execute information; the slave returns fetch PC and prediction.
interface btb_next_pc_if #(
  parameter int PC_W = 32
);
  logic            stall_F;
  logic [1:0]      predict;
  logic            branch_E;
  logic            jump_E;
  logic            take_E;
  logic [PC_W-1:0] pc_E;
  logic [PC_W-1:0] target_E;
  logic            pred_taken_E;
  logic [PC_W-1:0] pred_target_E;

  logic [PC_W-1:0] pc_F;
  logic            pred_taken_F;
  logic [PC_W-1:0] pred_target_F;
  logic            redirect_E;
  logic [31:0]     mispredict_cnt;
  logic [31:0]     ctrl_cnt;

  modport master (
    output stall_F, predict, branch_E, jump_E, take_E, pc_E, target_E,
           pred_taken_E, pred_target_E,
    input  pc_F, pred_taken_F, pred_target_F, redirect_E, mispredict_cnt, ctrl_cnt
  );

  modport slave (
    input  stall_F, predict, branch_E, jump_E, take_E, pc_E, target_E,
           pred_taken_E, pred_target_E,
    output pc_F, pred_taken_F, pred_target_F, redirect_E, mispredict_cnt, ctrl_cnt
  );
endinterface

// File: rtl/btb_next_pc.sv
// Fetch PC register with a direct-mapped BTB: predicts the next fetch address, repairs
// mispredictions resolved in Execute one cycle later, and trains the BTB on taken control flow.
module btb_next_pc #(
  parameter int              ENTRIES  = 64,
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input logic          clk,
  input logic          rst_n,
  btb_next_pc_if.slave bus
);
  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX - 2;

  typedef logic [IDX-1:0]   idx_t;
  typedef logic [TAG_W-1:0] tag_t;

  function automatic idx_t idx_of(input logic [PC_W-1:0] pc);
    return pc[IDX+1:2];
  endfunction

  function automatic tag_t tag_of(input logic [PC_W-1:0] pc);
    return pc[PC_W-1:IDX+2];
  endfunction

  logic [PC_W-1:0]    pc_q;
  logic [ENTRIES-1:0] valid_q;
  tag_t               tag_q    [ENTRIES];
  logic [PC_W-1:0]    target_q [ENTRIES];
  logic [ENTRIES-1:0] jump_q;
  logic [31:0]        mispredict_cnt_q;
  logic [31:0]        ctrl_cnt_q;

  // Fetch-side lookup; a same-cycle training write is only seen on the following cycle.
  idx_t idx_f;
  logic hit_f;
  logic pred_taken_f;

  assign idx_f        = idx_of(pc_q);
  assign hit_f        = valid_q[idx_f] && (tag_q[idx_f] == tag_of(pc_q));
  assign pred_taken_f = hit_f && (jump_q[idx_f] || bus.predict[1]);

  // Only the direction bit of the PHT counter matters here.
  logic unused_predict_lo;
  assign unused_predict_lo = bus.predict[0];

  // Execute-side resolution.
  idx_t            idx_e;
  logic            ctrl_e;
  logic            act_e;
  logic            redirect_e;
  logic [PC_W-1:0] correct_pc;
  logic [PC_W-1:0] next_pc;

  assign idx_e      = idx_of(bus.pc_E);
  assign ctrl_e     = bus.branch_E || bus.jump_E;
  assign act_e      = bus.jump_E || (bus.branch_E && bus.take_E);
  assign correct_pc = act_e ? bus.target_E : bus.pc_E + PC_W'(4);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    redirect_e = 1'b0;
    if (ctrl_e) begin
      redirect_e = (act_e != bus.pred_taken_E)
                || (act_e && bus.pred_taken_E && (bus.target_E != bus.pred_target_E));
    end else begin
      // A predicted-taken non-control instruction is a BTB alias.
      redirect_e = bus.pred_taken_E;
    end
  end

  always_comb begin
    next_pc = pc_q + PC_W'(4);
    if (redirect_e) begin
      next_pc = correct_pc;
    end else if (bus.stall_F) begin
      next_pc = pc_q;
    end else if (pred_taken_f) begin
      next_pc = target_q[idx_f];
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      pc_q             <= RESET_PC;
      valid_q          <= '0;
      mispredict_cnt_q <= '0;
      ctrl_cnt_q       <= '0;
    end else begin
      pc_q <= next_pc;

      if (act_e) begin
        valid_q[idx_e] <= 1'b1;
      end else if (!ctrl_e && bus.pred_taken_E) begin
        valid_q[idx_e] <= 1'b0;
      end

      if (ctrl_e && (ctrl_cnt_q != '1)) begin
        ctrl_cnt_q <= ctrl_cnt_q + 32'd1;
      end
      if (redirect_e && (mispredict_cnt_q != '1)) begin
        mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
      end
    end
  end

  // NOTE: the BTB payload arrays are deliberately not reset; valid_q alone qualifies them.
  always_ff @(posedge clk) begin
    if (rst_n && act_e) begin
      tag_q[idx_e]    <= tag_of(bus.pc_E);
      target_q[idx_e] <= bus.target_E;
      jump_q[idx_e]   <= bus.jump_E;
    end
  end

  assign bus.pc_F           = pc_q;
  assign bus.pred_taken_F   = pred_taken_f;
  assign bus.pred_target_F  = target_q[idx_f];
  assign bus.redirect_E     = redirect_e;
  assign bus.mispredict_cnt = mispredict_cnt_q;
  assign bus.ctrl_cnt       = ctrl_cnt_q;
endmodule

// File: tb/tb_btb_next_pc.sv
// Scoreboard bench for btb_next_pc: a behavioural model predicts every cycle's outputs,
// a separate monitor compares them; directed scenarios are followed by random traffic.
module tb_btb_next_pc;
  localparam int          ENTRIES  = 64;
  localparam int          PC_W     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  btb_next_pc_if #(.PC_W(PC_W)) bus ();

  btb_next_pc #(
    .ENTRIES (ENTRIES),
    .PC_W    (PC_W),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, actual, expected, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] target;
    bit          is_jump;
  } entry_t;

  typedef struct {
    logic [31:0] pc;
    bit          pt;
    logic [31:0] ptgt;
    bit          redirect;
    logic [31:0] mcnt;
    logic [31:0] ccnt;
  } exp_t;

  entry_t      m_btb [int];
  logic [31:0] m_pc;
  logic [31:0] m_mcnt;
  logic [31:0] m_ccnt;
  bit          m_known = 1'b0;
  exp_t        exp_q [$];

  function automatic int slot(input logic [31:0] pc);
    return int'((pc / 32'd4) % 32'(ENTRIES));
  endfunction

  function automatic bit same_line(input logic [31:0] a, input logic [31:0] b);
    return (a / 32'(4 * ENTRIES)) == (b / 32'(4 * ENTRIES));
  endfunction

  // One clock: drive inputs, queue the expected outputs, advance the model past the edge.
  task automatic step(input bit rst, input bit stall, input logic [1:0] pred,
                      input bit br, input bit jp, input bit tk,
                      input logic [31:0] pce, input logic [31:0] tgt,
                      input bit pte, input logic [31:0] ptg);
    exp_t        e;
    bit          hit, pt, ctrl, act, redir;
    logic [31:0] ptgt, fix;
    int          s;
    @(negedge clk);
    rst_n             = rst;
    bus.stall_F       = stall;
    bus.predict       = pred;
    bus.branch_E      = br;
    bus.jump_E        = jp;
    bus.take_E        = tk;
    bus.pc_E          = pce;
    bus.target_E      = tgt;
    bus.pred_taken_E  = pte;
    bus.pred_target_E = ptg;

    s    = slot(m_pc);
    hit  = m_btb.exists(s) ? same_line(m_btb[s].pc, m_pc) : 1'b0;
    pt   = 1'b0;
    ptgt = 32'h0;
    if (hit) begin
      pt   = m_btb[s].is_jump || pred[1];
      ptgt = m_btb[s].target;
    end
    ctrl = br || jp;
    act  = jp || (br && tk);
    if (ctrl) redir = (act != pte) || (act && pte && (tgt != ptg));
    else      redir = pte;
    fix  = act ? tgt : pce + 32'd4;

    if (m_known) begin
      e.pc       = m_pc;
      e.pt       = pt;
      e.ptgt     = ptgt;
      e.redirect = redir;
      e.mcnt     = m_mcnt;
      e.ccnt     = m_ccnt;
      exp_q.push_back(e);
    end

    if (!rst) begin
      m_pc    = RESET_PC;
      m_btb.delete();
      m_mcnt  = 32'h0;
      m_ccnt  = 32'h0;
      m_known = 1'b1;
    end else if (m_known) begin
      if (redir)      m_pc = fix;
      else if (pt && !stall) m_pc = ptgt;
      else if (!stall) m_pc = m_pc + 32'd4;
      if (act) begin
        m_btb[slot(pce)] = '{pc: pce, target: tgt, is_jump: jp};
      end else if (!ctrl && pte) begin
        m_btb.delete(slot(pce));
      end
      if (ctrl && m_ccnt != 32'hFFFF_FFFF)  m_ccnt = m_ccnt + 32'd1;
      if (redir && m_mcnt != 32'hFFFF_FFFF) m_mcnt = m_mcnt + 32'd1;
    end
  endtask

  task automatic idle(input logic [1:0] pred, input bit stall);
    step(1'b1, stall, pred, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  // Mispredicted not-taken branch just before a: redirects fetch to a without training.
  task automatic steer(input logic [31:0] a);
    step(1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, a - 32'd4, 32'h0, 1'b1, a);
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pc_F", bus.pc_F, e.pc);
        check("pred_taken_F", 32'(bus.pred_taken_F), 32'(e.pt));
        if (e.pt) check("pred_target_F", bus.pred_target_F, e.ptgt);
        check("redirect_E", 32'(bus.redirect_E), 32'(e.redirect));
        check("mispredict_cnt", bus.mispredict_cnt, e.mcnt);
        check("ctrl_cnt", bus.ctrl_cnt, e.ccnt);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  logic [31:0] pool [8] = '{32'h10, 32'h20, 32'h120, 32'h40, 32'h80, 32'h200, 32'h1020, 32'hFFFF_FFFC};

  function automatic logic [31:0] pick();
    if ($urandom_range(0, 7) == 0) return $urandom & 32'hFFFF_FFFC;
    return pool[$urandom_range(0, 7)];
  endfunction

  initial begin
    rst_n = 1'b0;
    bus.stall_F = 1'b0; bus.predict = 2'b00; bus.branch_E = 1'b0; bus.jump_E = 1'b0;
    bus.take_E = 1'b0; bus.pc_E = '0; bus.target_E = '0; bus.pred_taken_E = 1'b0;
    bus.pred_target_E = '0;

    repeat (2) step(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);

    // Free-running fetch after reset.
    idle(2'b00, 1'b0); #1;
    check("reset pc_F", bus.pc_F, 32'h0);
    check("reset pred_taken_F", 32'(bus.pred_taken_F), 32'h0);
    check("reset mispredict_cnt", bus.mispredict_cnt, 32'h0);
    check("reset ctrl_cnt", bus.ctrl_cnt, 32'h0);
    idle(2'b00, 1'b0); #1; check("seq pc 4", bus.pc_F, 32'h4);
    idle(2'b00, 1'b0); #1; check("seq pc 8", bus.pc_F, 32'h8);
    idle(2'b00, 1'b0); #1; check("seq pc C", bus.pc_F, 32'hC);

    // JAL at 0x10 -> 0x80, unpredicted.
    step(1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 32'h10, 32'h80, 1'b0, 32'h0); #1;
    check("jal redirect", 32'(bus.redirect_E), 32'h1);
    idle(2'b00, 1'b0); #1;
    check("jal pc_F", bus.pc_F, 32'h80);
    check("jal mispredict_cnt", bus.mispredict_cnt, 32'h1);
    check("jal ctrl_cnt", bus.ctrl_cnt, 32'h1);
    steer(32'h10);
    idle(2'b00, 1'b0); #1;
    check("jal refetch pc", bus.pc_F, 32'h10);
    check("jal hit pred_taken", 32'(bus.pred_taken_F), 32'h1);
    check("jal hit target", bus.pred_target_F, 32'h80);
    idle(2'b00, 1'b0); #1; check("jal follow", bus.pc_F, 32'h80);

    // Branch 0x20 -> 0x40, direction from PHT.
    step(1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 32'h20, 32'h40, 1'b0, 32'h0);
    steer(32'h20);
    idle(2'b01, 1'b0); #1; check("weak pht no take", 32'(bus.pred_taken_F), 32'h0);
    idle(2'b00, 1'b0); #1; check("weak pht pc", bus.pc_F, 32'h24);
    steer(32'h20);
    idle(2'b10, 1'b0); #1; check("strong pht take", 32'(bus.pred_taken_F), 32'h1);
    idle(2'b00, 1'b0); #1; check("strong pht pc", bus.pc_F, 32'h40);

    // Predicted taken, resolved not taken.
    step(1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0, 1'b1, 32'h40); #1;
    check("nt redirect", 32'(bus.redirect_E), 32'h1);
    idle(2'b00, 1'b0); #1; check("nt pc", bus.pc_F, 32'h24);
    steer(32'h20);
    idle(2'b10, 1'b0); #1; check("nt entry kept", 32'(bus.pred_taken_F), 32'h1);

    // Alias at 0x120 on a non-control instruction.
    step(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 32'h120, 32'h0, 1'b1, 32'h40); #1;
    check("alias redirect", 32'(bus.redirect_E), 32'h1);
    idle(2'b00, 1'b0); #1; check("alias pc", bus.pc_F, 32'h124);
    steer(32'h20);
    idle(2'b10, 1'b0); #1; check("alias cleared", 32'(bus.pred_taken_F), 32'h0);

    // Stall hold, then redirect overriding stall.
    steer(32'h30);
    idle(2'b00, 1'b1); #1; check("stall pc 1", bus.pc_F, 32'h30);
    idle(2'b00, 1'b1); #1; check("stall pc 2", bus.pc_F, 32'h30);
    step(1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 32'h50, 32'h200, 1'b0, 32'h0); #1;
    check("stall pc 3", bus.pc_F, 32'h30);
    idle(2'b00, 1'b0); #1; check("redirect over stall", bus.pc_F, 32'h200);

    // PC wrap-around.
    steer(32'hFFFF_FFFC);
    idle(2'b00, 1'b0); #1; check("wrap top", bus.pc_F, 32'hFFFF_FFFC);
    idle(2'b00, 1'b0); #1; check("wrap zero", bus.pc_F, 32'h0);

    // Reset mid-operation while a redirect is pending.
    step(1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 32'h10, 32'h80, 1'b0, 32'h0);
    step(1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 32'h60, 32'h400, 1'b0, 32'h0); #1;
    check("rst redirect comb", 32'(bus.redirect_E), 32'h1);
    idle(2'b00, 1'b0); #1;
    check("rst pc", bus.pc_F, RESET_PC);
    check("rst ctrl_cnt", bus.ctrl_cnt, 32'h0);
    steer(32'h10);
    idle(2'b10, 1'b0); #1; check("rst btb cleared", 32'(bus.pred_taken_F), 32'h0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      bit          r, st, br, jp, tk, pte;
      int          kind;
      logic [31:0] pce, tgt, ptg;
      r    = ($urandom_range(0, 299) != 0);
      st   = ($urandom_range(0, 4) == 0);
      kind = $urandom_range(0, 9);
      pce  = pick();
      tgt  = pick();
      br   = (kind >= 4 && kind <= 6);
      jp   = (kind >= 7);
      tk   = $urandom_range(0, 1);
      pte  = (kind <= 3) ? ($urandom_range(0, 5) == 0) : bit'($urandom_range(0, 1));
      ptg  = $urandom_range(0, 1) ? tgt : pick();
      step(r, st, 2'($urandom_range(0, 3)), br, jp, tk, pce, tgt, pte, ptg);
    end

    repeat (3) idle(2'b00, 1'b0);
    @(negedge clk); #3;
    check("scoreboard drained", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
